// File: rtl/fifo_uart_drain.sv
// Drains the byte FIFO into an 8N1 UART frame on tx. Define FIFO_UART_PARITY_EN
// to insert an even parity bit after the data bits (8E1).
`timescale 1ns/1ps

module fifo_uart_drain #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_d;
    logic              rd_en_d;
    logic              busy_d;
    logic [7:0]        frames_d;
`ifdef FIFO_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
`ifdef FIFO_UART_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx          <= tx_d;
            fifo_rd_en  <= rd_en_d;
            busy        <= busy_d;
            frames_sent <= frames_d;
`ifdef FIFO_UART_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next state; outputs are computed for the next cycle so they leave a flop
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        rd_en_d  = 1'b0;
        frames_d = frames_sent;
`ifdef FIFO_UART_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_POP;
                    rd_en_d = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_data;
`ifdef FIFO_UART_PARITY_EN
                par_d   = ^fifo_data;
`endif
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
                tx_d    = 1'b0;
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef FIFO_UART_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d   = '0;
                    frames_d = frames_sent + 8'd1;
                    state_d  = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: FIFO model, UART receive monitor and scoreboard.
`timescale 1ns/1ps

module tb_fifo_uart_drain;

    localparam int unsigned CPB = 4;
`ifdef FIFO_UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    always #5 clk = ~clk;

    fifo_uart_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data   (fifo_data),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    // 8-deep FIFO model with registered data_out
    logic [7:0] mem [8];
    int         fifo_count;
    int         wp;
    int         rp;
    int         pop_empty_viol;
    logic       push_req = 1'b0;
    logic [7:0] push_data = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count     <= 0;
            wp             <= 0;
            rp             <= 0;
            fifo_data      <= 8'h00;
            pop_empty_viol <= 0;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_count == 0) begin
                    pop_empty_viol <= pop_empty_viol + 1;
                end else begin
                    fifo_data <= mem[rp];
                    rp        <= (rp + 1) % 8;
                end
            end
            if (push_req && fifo_count < 8) begin
                mem[wp] <= push_data;
                wp      <= (wp + 1) % 8;
            end
            fifo_count <= fifo_count + ((push_req && fifo_count < 8) ? 1 : 0)
                                     - ((fifo_rd_en && fifo_count > 0) ? 1 : 0);
        end
    end

    assign fifo_empty = (fifo_count == 0);

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    exp_t vecs[8];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   rx_cnt = 0;
    int   rd_wide = 0;
    int   last_rd_cyc = 0;
    int   last_end_cyc = 0;
    int   b2b_first = 0;
    logic b2b_mode = 1'b0;
    int   exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_frame(input logic [NB-1:0] bits, input int len);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got frame data %02h expected none", bits[8:1]);
            return;
        end
        e = exp_q.pop_front();
        check("start_bit", 32'(bits[0]), 32'd0);
        check("rx_data", 32'(bits[8:1]), 32'(e.data));
`ifdef FIFO_UART_PARITY_EN
        check("parity_bit", 32'(bits[9]), 32'(e.par));
`endif
        check("stop_bit", 32'(bits[NB-1]), 32'd1);
        check("frame_len", 32'(len), 32'(CPB * NB));
    endtask

    // Receive monitor: decodes frames at mid-bit and scores them
    task automatic monitor();
        logic          in_frame = 1'b0;
        int            cnt = 0;
        logic [NB-1:0] bits = '0;
        logic          tx_prev = 1'b1;
        logic          rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame = 1'b0;
                tx_prev  = 1'b1;
                rd_prev  = 1'b0;
                continue;
            end
            if (fifo_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (rd_prev) rd_wide++;
            end
            rd_prev = fifo_rd_en;
            if (!in_frame) begin
                if (tx == 1'b0 && tx_prev) begin
                    in_frame = 1'b1;
                    cnt      = 0;
                    bits     = '0;
                    check("tx_latency", 32'(cyc - last_rd_cyc), 32'd2);
                    if (b2b_mode && rx_cnt >= b2b_first)
                        check("b2b_gap", 32'(cyc - last_end_cyc), 32'd3);
                end
            end else begin
                cnt++;
            end
            if (in_frame) begin
                if (cnt % CPB == 2 && cnt / CPB < NB) bits[cnt / CPB] = tx;
                if (!busy) begin
                    finish_frame(bits, cnt);
                    in_frame     = 1'b0;
                    last_end_cyc = cyc;
                    rx_cnt++;
                end else if (cnt > int'(CPB * NB) + 8) begin
                    check("frame_timeout", 32'(cnt), 32'(CPB * NB));
                    in_frame = 1'b0;
                end
            end
            tx_prev = tx;
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic p);
        exp_t e;
        @(negedge clk);
        push_req  = 1'b1;
        push_data = d;
        e.data    = d;
        e.par     = p;
        exp_q.push_back(e);
        @(negedge clk);
        push_req = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rx_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: got %0d frames expected %0d", rx_cnt, target);
        end
    endtask

    task automatic wait_space();
        int n = 0;
        while (fifo_count >= 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (fifo_count >= 8) begin
            checks++;
            errors++;
            $display("FAIL fifo_space_timeout: got level %0d expected below 8", fifo_count);
        end
    endtask

    initial begin
        int   base_rd;
        int   base_rx;
        int   bad;
        int   n;
        int   nwrap;
        logic [7:0] r;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h3C, 1'b0};
        vecs[7] = '{8'h01, 1'b1};

        fork
            monitor();
        join_none

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames from the vector table
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_byte(vecs[i].data, vecs[i].par);
            wait_rx(i + 1, 200);
            exp_frames++;
            check("frames_sent_single", 32'(frames_sent), 32'(exp_frames));
        end

        // Asynchronous reset in the middle of a frame
        push_byte(8'h81, 1'b0);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("midrst_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        @(negedge clk);

        // Burst of 8 bytes, back-to-back frames
        base_rd   = rd_cnt;
        base_rx   = rx_cnt;
        b2b_first = rx_cnt + 1;
        b2b_mode  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = 8'(i);
            push_byte(r, ^r);
        end
        wait_rx(base_rx + 8, 8 * (int'(CPB * NB) + 10));
        b2b_mode = 1'b0;
        exp_frames += 8;
        repeat (20) @(negedge clk);
        check("burst_rd_pulses", 32'(rd_cnt - base_rd), 32'd8);
        check("burst_frames", 32'(frames_sent), 32'(exp_frames));
        check("pop_when_empty", 32'(pop_empty_viol), 32'd0);

        // Empty FIFO, enabled: nothing happens
        base_rd = rd_cnt;
        bad     = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_rd_pulses", 32'(rd_cnt - base_rd), 32'd0);
        check("empty_idle_line", 32'(bad), 32'd0);

        // enable dropped during the second of three frames
        base_rd = rd_cnt;
        base_rx = rx_cnt;
        push_byte(8'h5A, 1'b0);
        push_byte(8'hC3, 1'b0);
        push_byte(8'h2F, 1'b1);
        n = 0;
        while (rd_cnt < base_rd + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_rx(base_rx + 2, 200);
        repeat (60) @(negedge clk);
        check("hold_rd_pulses", 32'(rd_cnt - base_rd), 32'd2);
        check("hold_fifo_level", 32'(fifo_count), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_rx(base_rx + 3, 200);
        exp_frames += 3;
        check("resume_rd_pulses", 32'(rd_cnt - base_rd), 32'd3);
        check("resume_frames", 32'(frames_sent), 32'(exp_frames));

        // Enough random frames to wrap frames_sent to zero
        nwrap   = (256 - (exp_frames % 256)) % 256;
        base_rx = rx_cnt;
        for (int i = 0; i < nwrap; i++) begin
            wait_space();
            r = 8'($urandom_range(0, 255));
            push_byte(r, ^r);
        end
        wait_rx(base_rx + nwrap, nwrap * (int'(CPB * NB) + 10) + 100);
        @(negedge clk);
        check("frames_wrap", 32'(frames_sent), 32'd0);
        check("final_pop_when_empty", 32'(pop_empty_viol), 32'd0);
        check("rd_en_width", 32'(rd_wide), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
